// File: rtl/kpn_fifo.sv
// kpn_fifo: single-clock synchronous FIFO with registered read data,
// occupancy counter, threshold flags and sticky overflow/underflow flags.
module kpn_fifo #(
  parameter int BITS_NUMBER        = 16,
  parameter int FIFO_ELEMENTS      = 5,
  parameter int ALMOST_FULL_LEVEL  = (2**FIFO_ELEMENTS) - 2,
  parameter int ALMOST_EMPTY_LEVEL = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     wr,
  input  logic [BITS_NUMBER-1:0]   entry_1,
  input  logic                     rd,
  output logic [BITS_NUMBER-1:0]   output_1,
  output logic                     output_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [FIFO_ELEMENTS:0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int DEPTH = 2**FIFO_ELEMENTS;
  localparam int CW    = FIFO_ELEMENTS + 1;
  localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] LP_AF    = CW'(ALMOST_FULL_LEVEL);
  localparam logic [CW-1:0] LP_AE    = CW'(ALMOST_EMPTY_LEVEL);

  logic [BITS_NUMBER-1:0]   r_mem [DEPTH];
  logic [FIFO_ELEMENTS-1:0] r_wptr, r_rptr;
  logic [CW-1:0]            r_count;
  logic [BITS_NUMBER-1:0]   r_out;
  logic                     r_valid, r_ovf, r_unf;

  logic w_full, w_empty, w_rd_acc, w_wr_acc;

  // Flags come straight from the registered count.
  assign w_full   = (r_count == LP_DEPTH);
  assign w_empty  = (r_count == '0);
  // A read on an empty FIFO is always rejected; a write on a full FIFO
  // is only accepted when a read frees a slot on the same edge.
  assign w_rd_acc = rd & ~w_empty;
  assign w_wr_acc = wr & (~w_full | w_rd_acc);

  assign output_1     = r_out;
  assign output_valid = r_valid;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= LP_AF);
  assign almost_empty = (r_count <= LP_AE);
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_unf;

  // Storage array; not reset, stale words are unreachable while empty.
  always_ff @(posedge clk) begin
    if (w_wr_acc && !clear) r_mem[r_wptr] <= entry_1;
  end

  // Pointers, occupancy, read data register and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (clear) begin
      // Flush wins over rd/wr; output_1 keeps its last value.
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_valid <= w_rd_acc;
      if (w_wr_acc) r_wptr <= r_wptr + FIFO_ELEMENTS'(1);
      if (w_rd_acc) begin
        r_out  <= r_mem[r_rptr];
        r_rptr <= r_rptr + FIFO_ELEMENTS'(1);
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (wr && !w_wr_acc) r_ovf <= 1'b1;
      if (rd && w_empty)   r_unf <= 1'b1;
    end
  end

endmodule

// File: doc/kpn_fifo.md
KPN_FIFO -- requirements
Module: kpn_fifo

Interface
REQ-001 Parameter BITS_NUMBER, default 16: data word width in bits.
REQ-002 Parameter FIFO_ELEMENTS, default 5: log2 of depth; DEPTH = 2**FIFO_ELEMENTS words.
REQ-003 Parameter ALMOST_FULL_LEVEL, default DEPTH-2: occupancy at or above which almost_full asserts.
REQ-004 Parameter ALMOST_EMPTY_LEVEL, default 2: occupancy at or below which almost_empty asserts.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 clear  input  1  synchronous flush; empties the FIFO in one cycle.
REQ-008 wr  input  1  write request.
REQ-009 entry_1  input  BITS_NUMBER  write data, sampled when wr=1.
REQ-010 rd  input  1  read request.
REQ-011 output_1  output  BITS_NUMBER  registered read data.
REQ-012 output_valid  output  1  one-cycle pulse marking new data on output_1.
REQ-013 full, empty  output  1 each  occupancy == DEPTH / occupancy == 0.
REQ-014 almost_full, almost_empty  output  1 each  threshold flags per REQ-003/004.
REQ-015 count  output  FIFO_ELEMENTS+1  current occupancy, 0..DEPTH.
REQ-016 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-017 Storage SHALL be a DEPTH x BITS_NUMBER array addressed by FIFO_ELEMENTS-bit write and read pointers that wrap modulo DEPTH.
REQ-018 Write accepted when wr=1 and (full=0, or rd is accepted in the same cycle); entry_1 stored at the write pointer, which then increments.
REQ-019 Read accepted when rd=1 and empty=0; output_1 takes the word at the read pointer on that edge, output_valid=1 for the next cycle, and the read pointer increments.
REQ-020 Read latency: data on output_1 with output_valid one cycle after the rd edge; output_1 holds its value until the next accepted read.
REQ-021 count: +1 on write-only accept, -1 on read-only accept, unchanged on both or neither; full, empty, almost_* derived combinationally from the registered count.
REQ-022 Simultaneous rd and wr when full: both accepted, count stays DEPTH, and overflow is not set.
REQ-023 Simultaneous rd and wr when empty: write accepted, read rejected, output_valid=0, underflow set, count becomes 1.
REQ-024 wr=1 while full without an accepted read: write dropped, storage and pointers unchanged, overflow set.
REQ-025 rd=1 while empty: no pointer change, output_1 unchanged, underflow set.
REQ-026 overflow and underflow remain set until rst_n=0 or clear=1.
REQ-027 clear=1 has priority over rd and wr in the same cycle: pointers=0, count=0, output_valid=0, overflow=underflow=0, and output_1 and array contents are unchanged.
REQ-028 Pointer wrap from DEPTH-1 to 0 SHALL not disturb count or flags.

Reset
REQ-029 rst_n=0 SHALL immediately, without a clock, force pointers=0, count=0, output_1=0, output_valid=0, overflow=underflow=0, empty=1, full=0, almost_empty=1, almost_full=0.
REQ-030 Array contents need not be reset; data from before reset is never readable, since empty=1.
REQ-031 Reset asserted mid-transfer SHALL discard all contents, and the first write after release SHALL be the first word read.
REQ-032 Deassertion of rst_n SHALL be synchronised externally; the block accepts wr and rd on the first rising edge after release.

Verification
REQ-033 Defaults: after reset, write 0x0001..0x0020 (32 words) -> full=1, count=32, almost_full=1 from count 30, overflow=0.
REQ-034 Full FIFO, write 0xBEEF with rd=0 -> overflow=1, count=32; then read 32 words -> output_1 sequence 0x0001..0x0020, each one cycle after rd, empty=1 at end.
REQ-035 Empty FIFO, rd=1 and wr=1 with entry_1=0x1234 -> underflow=1, output_valid=0, count=1; next rd -> output_1=0x1234.
REQ-036 Full FIFO, rd=wr=1 for 40 cycles with incrementing data -> count stays 32, no overflow, read order preserved across pointer wrap.
REQ-037 Count 10 with overflow=1, assert clear with wr=1 -> count=0, empty=1, overflow=0, and the write is dropped.
REQ-038 Pulse rst_n low between clock edges mid-stream -> all outputs reach reset values before the next edge; the following write/read returns only new data.
